// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: shared constants, fault codes and fetch states
package instruction_fetch_unit_pkg;
  localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;
  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_RANGE = 2'b10;
  typedef enum logic [1:0] {S_FETCH, S_STALL, S_FAULT} state_t;
endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// fetch_queue: small synchronous FIFO holding {instruction, pc} entries
module fetch_queue #(
  parameter int W = 64,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [W-1:0] data,
  output logic [W-1:0] q,
  output logic [$clog2(DEPTH):0] count,
  output logic empty,
  output logic full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= data;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  assign q = mem[rd_ptr];
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, ROM address, fetch queue, redirects and fetch faults
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int MEMORY_DEPTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE = TEXT_BASE_DEFAULT,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  output logic [DATA_WIDTH-1:0] Address_o,
  input  logic [DATA_WIDTH-1:0] Instruction_i,
  input  logic Redirect_i,
  input  logic [DATA_WIDTH-1:0] Redirect_target_i,
  output logic Valid_o,
  input  logic Ready_i,
  output logic [DATA_WIDTH-1:0] Instruction_o,
  output logic [DATA_WIDTH-1:0] PC_o,
  output logic Fault_o,
  output logic [1:0] Fault_cause_o
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [DATA_WIDTH:0] PC_LO = {1'b0, TEXT_BASE};
  localparam logic [DATA_WIDTH:0] PC_HI = PC_LO + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);
  state_t state, state_next;
  logic [DATA_WIDTH-1:0] pc;
  logic [1:0] cause;
  logic legal, push, pop, empty, full;
  logic [CW-1:0] count;
  logic [2*DATA_WIDTH-1:0] head;
  // range compare is one bit wider so the top of the window cannot wrap
  assign cause = pc[1:0] != 2'b00 ? FC_MISALIGN :
                 ({1'b0, pc} < PC_LO || {1'b0, pc} >= PC_HI) ? FC_RANGE : FC_NONE;
  assign legal = cause == FC_NONE;
  always_comb begin
    pop = Valid_o && Ready_i;
    push = !Redirect_i && legal && (count < CW'(QUEUE_DEPTH) || pop);
    state_next = Redirect_i ? S_FETCH : !legal ? S_FAULT : (full && !pop) ? S_STALL : S_FETCH;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      pc <= TEXT_BASE;
    end else begin
      state <= state_next;
      pc <= Redirect_i ? Redirect_target_i : push ? pc + DATA_WIDTH'(4) : pc;
    end
  end
  fetch_queue #(.W(2*DATA_WIDTH), .DEPTH(QUEUE_DEPTH)) u_queue (
    .clk(clk),
    .rst(reset),
    .push(push),
    .pop(pop),
    .flush(Redirect_i),
    .data({Instruction_i, pc}),
    .q(head),
    .count(count),
    .empty(empty),
    .full(full)
  );
  assign Address_o = pc;
  assign Valid_o = !empty;
  assign Instruction_o = Valid_o ? head[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
  assign PC_o = Valid_o ? head[DATA_WIDTH-1:0] : '0;
  assign Fault_o = state == S_FAULT;
  assign Fault_cause_o = Fault_o ? cause : FC_NONE;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: random + directed scoreboard bench for the fetch unit
module tb_instruction_fetch_unit;
  localparam int MD = 64;
  localparam int QD = 2;
  localparam logic [31:0] BASE = 32'h0040_0000;
  logic clk = 0, reset = 1;
  logic [31:0] Address_o, Instruction_i, Instruction_o, PC_o;
  logic [31:0] Redirect_target_i = 0;
  logic Redirect_i = 0, Ready_i = 0, Valid_o, Fault_o;
  logic [1:0] Fault_cause_o;
  int compared = 0, mismatched = 0;
  logic [31:0] mpc = BASE;
  int mcount = 0;
  bit mfault = 0;
  logic [1:0] mcause = 0;
  logic [63:0] exp_q[$];
  always #5 clk = ~clk;
  instruction_fetch_unit #(.MEMORY_DEPTH(MD), .DATA_WIDTH(32), .TEXT_BASE(BASE), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .reset(reset), .Address_o(Address_o), .Instruction_i(Instruction_i),
    .Redirect_i(Redirect_i), .Redirect_target_i(Redirect_target_i), .Valid_o(Valid_o),
    .Ready_i(Ready_i), .Instruction_o(Instruction_o), .PC_o(PC_o), .Fault_o(Fault_o),
    .Fault_cause_o(Fault_cause_o)
  );
  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'hA000_0000 + ((a - BASE) >> 2);
  endfunction
  function automatic logic [1:0] cause_of(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 2'b01;
    if (a < BASE || (a - BASE) >= 4 * MD) return 2'b10;
    return 2'b00;
  endfunction
  assign Instruction_i = rom(Address_o);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask
  // reference model: one step per clock edge, pushing expected deliveries
  always @(posedge clk) begin
    bit pop;
    if (reset) begin
      mpc = BASE; mcount = 0; mfault = 0; mcause = 0; exp_q.delete();
    end else begin
      pop = mcount > 0 && Ready_i;
      if (Redirect_i) begin
        mpc = Redirect_target_i; mcount = 0; mfault = 0; mcause = 0; exp_q.delete();
      end else begin
        if (pop) mcount--;
        if (cause_of(mpc) != 2'b00) begin
          mfault = 1; mcause = cause_of(mpc);
        end else if (mcount < QD) begin
          exp_q.push_back({rom(mpc), mpc});
          mpc += 4;
          mcount++;
        end
      end
    end
  end
  always @(negedge clk) begin
    logic [63:0] e;
    if (!reset) begin
      chk("valid", {31'b0, Valid_o}, {31'b0, mcount != 0});
      chk("address", Address_o, mpc);
      chk("fault", {31'b0, Fault_o}, {31'b0, mfault});
      chk("cause", {30'b0, Fault_cause_o}, {30'b0, mfault ? mcause : 2'b00});
      if (!Valid_o) begin
        chk("empty_pc", PC_o, 32'h0);
        chk("empty_instr", Instruction_o, 32'h0);
      end else if (Ready_i) begin
        if (exp_q.size() == 0) chk("unexpected_pop", PC_o, 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("pc", PC_o, e[31:0]);
          chk("instr", Instruction_o, e[63:32]);
        end
      end
    end
  end
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic redirect(input logic [31:0] t, input logic rdy);
    Ready_i = rdy; Redirect_i = 1; Redirect_target_i = t;
    step();
    Redirect_i = 0;
  endtask
  initial begin
    step(2);
    reset = 0; Ready_i = 1;
    step(6);
    Ready_i = 0; step(5);
    Ready_i = 1; step(4);
    Ready_i = 0; step(3);
    redirect(BASE + 32'h40, 1);
    step(4);
    redirect(BASE + 32'h42, 1);
    step(4);
    redirect(BASE, 1);
    step(4);
    redirect(BASE + 32'hF8, 1);
    step(6);
    redirect(BASE + 32'hF8, 0);
    step(6);
    reset = 1; step();
    reset = 0; Ready_i = 1;
    step(4);
    redirect(BASE - 32'h4, 1);
    step(3);
    for (int i = 0; i < 3000; i++) begin
      Ready_i = ($urandom % 4) != 0;
      Redirect_i = ($urandom % 40) == 0;
      Redirect_target_i = BASE + 4 * $urandom_range(0, 70) + (($urandom % 8) == 0 ? 32'd2 : 32'd0);
      if (($urandom % 16) == 0) Redirect_target_i = BASE + 4 * $urandom_range(56, 63);
      reset = ($urandom % 300) == 0;
      step();
    end
    Redirect_i = 0; reset = 0; Ready_i = 1;
    step(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch-side initiator for the asynchronous-read program memory.
- Holds the program counter and drives the byte address to the ROM. Captures the same-cycle instruction word into a small in-order instruction queue and presents it to decode over a valid/ready handshake.
- Handles control-flow redirects (branch/jump) with a queue flush. Detects illegal fetch addresses.

Parameters:
- MEMORY_DEPTH, 64, program memory depth in 32-bit words
- DATA_WIDTH, 32, address/instruction width
- TEXT_BASE, 32'h0040_0000, byte address of ROM word 0 (reset PC)
- QUEUE_DEPTH, 2, instruction queue entries (power of 2, >=2)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- Address_o  out  DATA_WIDTH  byte address to program memory (equals fetch PC register)
- Instruction_i  in  DATA_WIDTH  instruction returned combinationally by program memory for Address_o
- Redirect_i  in  1  load new fetch PC, flush queue
- Redirect_target_i  in  DATA_WIDTH  new byte PC
- Valid_o  out  1  queue head valid
- Ready_i  in  1  decode accepts head this cycle
- Instruction_o  out  DATA_WIDTH  head instruction (0 when empty)
- PC_o  out  DATA_WIDTH  byte PC of head instruction (0 when empty)
- Fault_o  out  1  fetch fault, sticky
- Fault_cause_o  out  2  01 misaligned PC, 10 PC out of range, 00 none

Behaviour:
- Reset is synchronous, active-high, and overrides all other inputs.
  - PC = TEXT_BASE, so Address_o = TEXT_BASE.
  - Queue is emptied: rd/wr pointers 0, count 0.
  - Valid_o = 0, Instruction_o = 0, PC_o = 0, Fault_o = 0, Fault_cause_o = 00, state = FETCH.
- A PC is legal iff PC[1:0] == 00 and TEXT_BASE <= PC < TEXT_BASE + 4*MEMORY_DEPTH. Compare in DATA_WIDTH+1 bits; no wrap.
- States:
  - FETCH: PC legal and queue not full.
  - STALL: queue full, no pop this cycle.
  - FAULT: illegal PC reached.
- push = state FETCH-eligible, PC legal, no Redirect_i, and (count < QUEUE_DEPTH, or a pop occurs this cycle).
  - On push: entry {Instruction_i, PC} is written at wr_ptr, and PC <= PC + 4.
- pop = Valid_o && Ready_i; advances rd_ptr.
- Push and pop in the same cycle leave count unchanged. A full queue with a pop still accepts a push, giving a sustained 1 instruction/cycle.
- Pointers are log2(QUEUE_DEPTH) bits and wrap naturally.
- Latency: PC issued in cycle N appears at Valid_o/Instruction_o in cycle N+1 if the queue was empty.
- Valid_o = (count != 0). Instruction_o and PC_o are driven from the head entry.
- Redirect_i has priority over push:
  - Next cycle, the queue is empty and PC = Redirect_target_i.
  - A pop in the same cycle is still counted as accepted by decode.
  - No push occurs in the redirect cycle.
  - Redirect clears FAULT and Fault_o/Fault_cause_o; the new PC is then checked normally.
- PC illegal while not redirecting → state FAULT:
  - No push, PC frozen (Address_o holds the faulting PC).
  - Existing entries still drain via pop.
  - Fault_o rises the cycle after entry and stays high until Redirect_i or reset.
  - Cause: misaligned takes precedence over out-of-range.
- The last legal word (TEXT_BASE + 4*(MEMORY_DEPTH-1)) is fetched normally. The following PC faults with cause 10.
- Reset asserted mid-stream discards queued entries. There is no residual Valid_o in the cycle after reset.

Decomposition:
- Shared package/header:
  - TEXT_BASE default
  - fault cause codes FC_NONE = 2'b00, FC_MISALIGN = 2'b01, FC_RANGE = 2'b10
  - state encodings S_FETCH, S_STALL, S_FAULT
- Sub-module fetch_queue:
  - Parameterised synchronous FIFO with width 2*DATA_WIDTH and QUEUE_DEPTH entries.
  - Ports: push, pop, flush, data, count, empty, full.
  - Instantiated once. The PC, legality checks and FSM stay in the top module.

Test Plan:
- Reset release, Ready_i = 1, ROM model returns 0xA000_0000+word index → cycle 1 Valid_o = 1, PC_o = 0x0040_0000, Instruction_o = 0xA000_0000; then one instruction per cycle with PC_o incrementing by 4.
- Ready_i = 0 for 5 cycles after first valid → queue fills to 2, Address_o frozen at 0x0040_0008, head held at PC 0x0040_0000. Ready_i = 1 → PCs 0x0040_0000, 0x0040_0004, 0x0040_0008 delivered in order, none dropped or duplicated.
- Redirect_i = 1, target 0x0040_0040 with queue full and Ready_i = 1 → the current head counts as accepted. Next cycle Valid_o = 0 and Address_o = 0x0040_0040; the cycle after, PC_o = 0x0040_0040, Instruction_o = 0xA000_0010.
- Redirect to 0x0040_0042 → one cycle later Fault_o = 1, Fault_cause_o = 01, Valid_o = 0. Redirect to 0x0040_0000 → fault cleared and fetch resumes.
- Redirect to 0x0040_00F8, MEMORY_DEPTH = 64 → PCs 0x0040_00F8 and 0x0040_00FC delivered, then Fault_cause_o = 10 with Address_o held at 0x0040_0100.
- Reset asserted while queue is full and in FAULT → next cycle Valid_o = 0, Fault_o = 0, Address_o = 0x0040_0000.
